key_angle_step_gen: RTL and testbench

//  Converts two raw, bouncing rotate buttons into clean single-cycle inc/dec step pulses for
//  the angle-offset adjuster (1 step = 0.25 deg, angle range 0..1439). Debounces each key and

---
 rtl/key_step_pkg.sv | 21 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/key_angle_step_gen.sv | 133 +++++++++++++
 tb/tb_key_angle_step_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/key_step_pkg.sv
// Shared types and helpers for the rotate-key step generator.
package key_step_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  localparam int DEF_DEBOUNCE_CYC     = 500000;
  localparam int DEF_REPEAT_DELAY_CYC = 25000000;
  localparam int DEF_SLOW_RATE_CYC    = 5000000;
  localparam int DEF_FAST_RATE_CYC    = 500000;
  localparam int DEF_FAST_AFTER       = 8;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low key.
module key_debounce
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_n;
  logic          sync2_n;
  logic          level_n;
  logic [CW-1:0] cnt;

  // The debounced level only follows the synced level after it has disagreed
  // for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_n <= 1'b1;
      sync2_n <= 1'b1;
      level_n <= 1'b1;
      cnt     <= '0;
    end else begin
      sync1_n <= key_n;
      sync2_n <= sync1_n;
      if (sync2_n == level_n) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_n <= sync2_n;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = ~level_n;

endmodule

// File: rtl/key_angle_step_gen.sv
// Debounced inc/dec keys to single-cycle step pulses with delayed slow/fast auto-repeat.
module key_angle_step_gen
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int SLOW_RATE_CYC    = DEF_SLOW_RATE_CYC,
  parameter int FAST_RATE_CYC    = DEF_FAST_RATE_CYC,
  parameter int FAST_AFTER       = DEF_FAST_AFTER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_inc_n,
  input  logic key_dec_n,
  output logic inc,
  output logic dec,
  output logic repeating
);

  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY_CYC < 1 || SLOW_RATE_CYC < 1 ||
      FAST_RATE_CYC < 1 || FAST_AFTER < 1) begin : g_bad_param
    $error("key_angle_step_gen: all cycle-count parameters must be >= 1");
  end

  localparam int TW = cnt_width(max_int(REPEAT_DELAY_CYC, max_int(SLOW_RATE_CYC, FAST_RATE_CYC)));
  localparam int RW = cnt_width(FAST_AFTER + 1);

  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_CYC - 1);
  localparam logic [TW-1:0] SLOW_LAST  = TW'(SLOW_RATE_CYC - 1);
  localparam logic [TW-1:0] FAST_LAST  = TW'(FAST_RATE_CYC - 1);
  localparam logic [RW-1:0] SLOW_LIMIT = RW'(FAST_AFTER);
  localparam logic [RW-1:0] REP_SAT    = RW'(FAST_AFTER + 1);

  logic          inc_p;
  logic          dec_p;
  state_t        state;
  logic          active_dec;
  logic [TW-1:0] tmr;
  logic [RW-1:0] rep_cnt;
  logic          own_p;
  logic          other_p;
  logic [TW-1:0] period_last;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_inc_n),
    .pressed (inc_p)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_dec_n),
    .pressed (dec_p)
  );

  // rep_cnt counts the delay-expiry pulse as repeat 1, so intervals that start
  // at repeats 1..FAST_AFTER run slow and every later interval runs fast.
  always_comb begin
    own_p       = active_dec ? dec_p : inc_p;
    other_p     = active_dec ? inc_p : dec_p;
    period_last = (rep_cnt <= SLOW_LIMIT) ? SLOW_LAST : FAST_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active_dec <= 1'b0;
      tmr        <= '0;
      rep_cnt    <= '0;
      inc        <= 1'b0;
      dec        <= 1'b0;
      repeating  <= 1'b0;
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      case (state)
        IDLE: begin
          repeating <= 1'b0;
          if (inc_p && dec_p) begin
            state <= LOCK;
          end else if (inc_p || dec_p) begin
            active_dec <= dec_p;
            inc        <= inc_p;
            dec        <= dec_p;
            tmr        <= '0;
            rep_cnt    <= '0;
            state      <= DELAY;
          end
        end
        DELAY: begin
          if (other_p) begin
            state <= LOCK;
          end else if (!own_p) begin
            state <= IDLE;
          end else if (tmr == DELAY_LAST) begin
            inc       <= ~active_dec;
            dec       <= active_dec;
            tmr       <= '0;
            rep_cnt   <= RW'(1);
            repeating <= 1'b1;
            state     <= REPEAT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        REPEAT: begin
          if (other_p) begin
            repeating <= 1'b0;
            state     <= LOCK;
          end else if (!own_p) begin
            repeating <= 1'b0;
            state     <= IDLE;
          end else if (tmr == period_last) begin
            inc <= ~active_dec;
            dec <= active_dec;
            tmr <= '0;
            if (rep_cnt != REP_SAT) rep_cnt <= rep_cnt + 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        LOCK: begin
          repeating <= 1'b0;
          if (!inc_p && !dec_p) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_angle_step_gen.sv
// Directed and table-driven checks for key_angle_step_gen with small cycle counts.
module tb_key_angle_step_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic key_inc_n;
  logic key_dec_n;
  logic inc;
  logic dec;
  logic repeating;

  key_angle_step_gen #(
    .DEBOUNCE_CYC     (4),
    .REPEAT_DELAY_CYC (20),
    .SLOW_RATE_CYC    (5),
    .FAST_RATE_CYC    (2),
    .FAST_AFTER       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_inc_n (key_inc_n),
    .key_dec_n (key_dec_n),
    .inc       (inc),
    .dec       (dec),
    .repeating (repeating)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;
  logic rep_seen = 1'b0;

  logic [15:0] exp_inc_q[$];
  logic [15:0] exp_dec_q[$];
  logic [15:0] obs_inc_q[$];
  logic [15:0] obs_dec_q[$];

  typedef struct {
    string name;
    bit    use_dec;
    int    low_cycles;
    bit    bounce;
    int    exp_count;
    int    exp_first;
  } tap_vec_t;

  tap_vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, log pulses, check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (inc) obs_inc_q.push_back(16'(cyc));
    if (dec) obs_dec_q.push_back(16'(cyc));
    if (repeating) rep_seen = 1'b1;
    check("inc_dec_exclusive", 32'(inc && dec), 32'd0);
    check("pulse_width_1", 32'((inc && prev_inc) || (dec && prev_dec)), 32'd0);
    prev_inc = inc;
    prev_dec = dec;
  endtask

  task automatic start_seq();
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    repeat (20) step();
    cyc = 0;
    rep_seen = 1'b0;
    exp_inc_q.delete();
    exp_dec_q.delete();
    obs_inc_q.delete();
    obs_dec_q.delete();
  endtask

  task automatic compare_pulses(input string name);
    check({name, "_inc_count"}, 32'(obs_inc_q.size()), 32'(exp_inc_q.size()));
    check({name, "_dec_count"}, 32'(obs_dec_q.size()), 32'(exp_dec_q.size()));
    for (int i = 0; i < exp_inc_q.size() && i < obs_inc_q.size(); i++)
      check({name, "_inc_at"}, 32'(obs_inc_q[i]), 32'(exp_inc_q[i]));
    for (int i = 0; i < exp_dec_q.size() && i < obs_dec_q.size(); i++)
      check({name, "_dec_at"}, 32'(obs_dec_q[i]), 32'(exp_dec_q[i]));
  endtask

  initial begin
    vecs[0] = '{"tap_inc_10",    1'b0, 10, 1'b0, 1, 7};
    vecs[1] = '{"tap_dec_10",    1'b1, 10, 1'b0, 1, 7};
    vecs[2] = '{"tap_inc_4",     1'b0,  4, 1'b0, 1, 7};
    vecs[3] = '{"tap_inc_3",     1'b0,  3, 1'b0, 0, 0};
    vecs[4] = '{"tap_dec_3",     1'b1,  3, 1'b0, 0, 0};
    vecs[5] = '{"bounce_dec_30", 1'b1, 30, 1'b1, 0, 0};
    vecs[6] = '{"bounce_inc_30", 1'b0, 30, 1'b1, 0, 0};

    rst_n = 1'b0;
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_inc", 32'(inc), 32'd0);
      check("reset_dec", 32'(dec), 32'd0);
      check("reset_repeating", 32'(repeating), 32'd0);
    end
    rst_n = 1'b1;

    // Taps and bounces: key level after step i is low while i < low_cycles.
    for (int v = 0; v < 7; v++) begin
      logic lvl;
      start_seq();
      for (int i = 0; i <= 60; i++) begin
        if (i > 0) step();
        lvl = 1'b1;
        if (i < vecs[v].low_cycles) lvl = vecs[v].bounce ? logic'(((i / 2) % 2) != 0) : 1'b0;
        if (vecs[v].use_dec) key_dec_n = lvl;
        else                 key_inc_n = lvl;
      end
      if (vecs[v].exp_count == 1) begin
        if (vecs[v].use_dec) exp_dec_q.push_back(16'(vecs[v].exp_first));
        else                 exp_inc_q.push_back(16'(vecs[v].exp_first));
      end
      compare_pulses(vecs[v].name);
      check({vecs[v].name, "_no_repeat"}, 32'(rep_seen), 32'd0);
    end

    // Long hold: first pulse, delay, three slow repeats, then fast.
    start_seq();
    key_inc_n = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      step();
      if (i == 26)  check("hold_rep_before", 32'(repeating), 32'd0);
      if (i == 27)  check("hold_rep_start", 32'(repeating), 32'd1);
      if (i == 106) check("hold_rep_last", 32'(repeating), 32'd1);
      if (i == 107) check("hold_rep_end", 32'(repeating), 32'd0);
      key_inc_n = !(i < 100);
    end
    exp_inc_q = '{16'd7, 16'd27, 16'd32, 16'd37, 16'd42};
    for (int t = 44; t <= 106; t += 2) exp_inc_q.push_back(16'(t));
    compare_pulses("hold_inc");

    // Second key during delay locks out; re-press after full release works.
    start_seq();
    key_inc_n = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      step();
      key_inc_n = !(i < 60);
      key_dec_n = !((i >= 17 && i < 80) || (i >= 100 && i < 110));
    end
    exp_inc_q.push_back(16'd7);
    exp_dec_q.push_back(16'd107);
    compare_pulses("lock");

    // Reset during fast repeat with key still held.
    start_seq();
    key_inc_n = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      step();
      if (i >= 51 && i <= 53) begin
        check("midreset_inc", 32'(inc), 32'd0);
        check("midreset_rep", 32'(repeating), 32'd0);
      end
      if (i == 60) check("postreset_rep_delay", 32'(repeating), 32'd0);
      if (i == 80) check("postreset_rep_on", 32'(repeating), 32'd1);
      if (i == 50) rst_n = 1'b0;
      if (i == 53) rst_n = 1'b1;
      key_inc_n = !(i < 84);
    end
    exp_inc_q = '{16'd7, 16'd27, 16'd32, 16'd37, 16'd42, 16'd44, 16'd46, 16'd48,
                  16'd50, 16'd60, 16'd80, 16'd85, 16'd90};
    compare_pulses("reset_hold");

    // Random key activity; invariants are checked every cycle in step().
    start_seq();
    begin
      int hold_inc = 1;
      int hold_dec = 1;
      for (int i = 0; i < 10000; i++) begin
        step();
        hold_inc--;
        hold_dec--;
        if (hold_inc <= 0) begin
          key_inc_n = ~key_inc_n;
          hold_inc = int'($urandom_range(1, 30));
        end
        if (hold_dec <= 0) begin
          key_dec_n = ~key_dec_n;
          hold_dec = int'($urandom_range(1, 30));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
